// File: rtl/trb_mem_scheduler.sv
// Time-division arbiter for the trace-buffer single-port RAM: the logger gets
// write/read-prefetch slots and the host gets the fourth slot, or every cycle when tracing is off.
module trb_mem_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  ENABLE_I,
    output logic                  RW_TURN_O,
    output logic                  WRITE_ALLOW_O,
    output logic                  READ_ALLOW_O,
    input  logic                  LOG_WRITE_I,
    input  logic [ADDR_WIDTH-1:0] LOG_WRITE_PTR_I,
    input  logic [DATA_WIDTH-1:0] LOG_DMEM_I,
    input  logic [ADDR_WIDTH-1:0] LOG_READ_PTR_I,
    output logic [DATA_WIDTH-1:0] LOG_DMEM_O,
    input  logic                  HOST_REQ_I,
    input  logic                  HOST_WE_I,
    input  logic [ADDR_WIDTH-1:0] HOST_ADDR_I,
    input  logic [DATA_WIDTH-1:0] HOST_WDATA_I,
    output logic                  HOST_GNT_O,
    output logic                  HOST_RVALID_O,
    output logic [DATA_WIDTH-1:0] HOST_RDATA_O,
    output logic                  MEM_EN_O,
    output logic                  MEM_WE_O,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR_O,
    output logic [DATA_WIDTH-1:0] MEM_WDATA_O,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA_I,
    output logic                  ERR_O
);

    typedef enum logic [1:0] {
        PH_W  = 2'd0,
        PH_RA = 2'd1,
        PH_RD = 2'd2,
        PH_H  = 2'd3
    } phase_t;

    phase_t                  phase_reg, phase_next;
    logic                    pf_valid_reg, pf_valid_next;
    logic [ADDR_WIDTH-1:0]   pf_addr_reg, pf_addr_next;
    logic                    rd_pend_reg;
    logic                    rvalid_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    err_reg;

    logic                    rw_turn, write_allow, read_allow, host_gnt;
    logic                    mem_en, mem_we, log_err;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata, log_dmem;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            phase_reg    <= PH_W;
            pf_valid_reg <= 1'b0;
            pf_addr_reg  <= '0;
            rd_pend_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            pf_valid_reg <= pf_valid_next;
            pf_addr_reg  <= pf_addr_next;
            rd_pend_reg  <= host_gnt && !HOST_WE_I;
            rvalid_reg   <= rd_pend_reg;
            if (rd_pend_reg) begin
                rdata_reg <= MEM_RDATA_I;
            end
            if (log_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        phase_next    = phase_t'(phase_reg + 2'd1);
        pf_valid_next = pf_valid_reg;
        pf_addr_next  = pf_addr_reg;
        rw_turn       = 1'b0;
        write_allow   = 1'b0;
        read_allow    = 1'b0;
        host_gnt      = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        log_dmem      = '0;
        if (ENABLE_I) begin
            case (phase_reg)
                PH_W: begin
                    rw_turn     = 1'b1;
                    write_allow = 1'b1;
                    if (LOG_WRITE_I) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = LOG_WRITE_PTR_I;
                        mem_wdata = LOG_DMEM_I;
                    end
                end
                PH_RA: begin
                    mem_en        = 1'b1;
                    mem_addr      = LOG_READ_PTR_I;
                    pf_addr_next  = LOG_READ_PTR_I;
                    pf_valid_next = 1'b1;
                end
                PH_RD: begin
                    // A pointer move since the prefetch means the word is stale.
                    log_dmem      = MEM_RDATA_I;
                    read_allow    = pf_valid_reg && (pf_addr_reg == LOG_READ_PTR_I);
                    pf_valid_next = 1'b0;
                end
                default: begin
                    host_gnt = HOST_REQ_I;
                end
            endcase
        end else begin
            pf_valid_next = 1'b0;
            host_gnt      = HOST_REQ_I;
        end
        if (host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = HOST_WE_I;
            mem_addr  = HOST_ADDR_I;
            mem_wdata = HOST_WDATA_I;
        end
        log_err = LOG_WRITE_I && !write_allow;
    end

    // Combinational outputs are forced low while reset is held.
    assign RW_TURN_O     = !RST_I && rw_turn;
    assign WRITE_ALLOW_O = !RST_I && write_allow;
    assign READ_ALLOW_O  = !RST_I && read_allow;
    assign HOST_GNT_O    = !RST_I && host_gnt;
    assign MEM_EN_O      = !RST_I && mem_en;
    assign MEM_WE_O      = !RST_I && mem_we;
    assign MEM_ADDR_O    = RST_I ? '0 : mem_addr;
    assign MEM_WDATA_O   = RST_I ? '0 : mem_wdata;
    assign LOG_DMEM_O    = RST_I ? '0 : log_dmem;
    assign HOST_RVALID_O = rvalid_reg;
    assign HOST_RDATA_O  = rdata_reg;
    assign ERR_O         = err_reg;

endmodule

// File: tb/tb_trb_mem_scheduler.sv
// Directed bench for trb_mem_scheduler with a behavioural single-port RAM and
// a scoreboard of expected host read returns (data and arrival cycle).
module tb_trb_mem_scheduler;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          CLK_I = 1'b0;
    logic          RST_I;
    logic          ENABLE_I;
    logic          RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O;
    logic          LOG_WRITE_I;
    logic [AW-1:0] LOG_WRITE_PTR_I, LOG_READ_PTR_I;
    logic [DW-1:0] LOG_DMEM_I, LOG_DMEM_O;
    logic          HOST_REQ_I, HOST_WE_I;
    logic [AW-1:0] HOST_ADDR_I;
    logic [DW-1:0] HOST_WDATA_I, HOST_RDATA_O;
    logic          HOST_GNT_O, HOST_RVALID_O;
    logic          MEM_EN_O, MEM_WE_O;
    logic [AW-1:0] MEM_ADDR_O;
    logic [DW-1:0] MEM_WDATA_O, MEM_RDATA_I;
    logic          ERR_O;

    trb_mem_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ENABLE_I(ENABLE_I),
        .RW_TURN_O(RW_TURN_O), .WRITE_ALLOW_O(WRITE_ALLOW_O), .READ_ALLOW_O(READ_ALLOW_O),
        .LOG_WRITE_I(LOG_WRITE_I), .LOG_WRITE_PTR_I(LOG_WRITE_PTR_I), .LOG_DMEM_I(LOG_DMEM_I),
        .LOG_READ_PTR_I(LOG_READ_PTR_I), .LOG_DMEM_O(LOG_DMEM_O),
        .HOST_REQ_I(HOST_REQ_I), .HOST_WE_I(HOST_WE_I), .HOST_ADDR_I(HOST_ADDR_I),
        .HOST_WDATA_I(HOST_WDATA_I), .HOST_GNT_O(HOST_GNT_O), .HOST_RVALID_O(HOST_RVALID_O),
        .HOST_RDATA_O(HOST_RDATA_O), .MEM_EN_O(MEM_EN_O), .MEM_WE_O(MEM_WE_O),
        .MEM_ADDR_O(MEM_ADDR_O), .MEM_WDATA_O(MEM_WDATA_O), .MEM_RDATA_I(MEM_RDATA_I),
        .ERR_O(ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Single-port synchronous RAM: read data appears the cycle after issue.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_rdata = '0;
    always @(posedge CLK_I) begin
        if (MEM_EN_O) begin
            if (MEM_WE_O) ram[MEM_ADDR_O] <= MEM_WDATA_O;
            else          ram_rdata <= ram[MEM_ADDR_O];
        end
    end
    assign MEM_RDATA_I = ram_rdata;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            tests = 0;
    int            fails = 0;
    int            ph = 0;
    int            cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check any host read return against the scoreboard.
    task automatic next();
        exp_t e;
        @(negedge CLK_I);
        cyc++;
        ph = RST_I ? 0 : (ph + 1) % 4;
        if (sb.size() > 0 && sb[0].cyc + 2 < cyc) begin
            e = sb.pop_front();
            chk("rvalid_missing", HOST_RVALID_O, 1'b1);
        end
        if (HOST_RVALID_O) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", HOST_RVALID_O, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("host_rdata", HOST_RDATA_O, e.data);
                chk("host_rlat", cyc, e.cyc + 2);
                $display("[TB] host read return data=%0h cycle=%0d", HOST_RDATA_O, cyc);
            end
        end
    endtask

    task automatic align(input int target);
        for (int k = 0; k < 4 && ph != target; k++) next();
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_t e;
        bit   done = 0;
        HOST_REQ_I = 1'b1; HOST_WE_I = we; HOST_ADDR_I = addr; HOST_WDATA_I = wdata;
        for (int k = 0; k < 6 && !done; k++) begin
            #1;
            if (HOST_GNT_O) begin
                if (ENABLE_I) chk("gnt_phase", ph, 3);
                if (we) begin
                    shadow[addr] = wdata;
                end else begin
                    e.data = shadow[addr];
                    e.cyc  = cyc;
                    sb.push_back(e);
                end
                $display("[TB] host %s addr=%0h grant cycle=%0d", we ? "write" : "read", addr, cyc);
                done = 1;
            end else if (ENABLE_I && ph == 3) begin
                chk("gnt_miss", HOST_GNT_O, 1'b1);
            end
            next();
        end
        HOST_REQ_I = 1'b0;
        chk("gnt_timeout", done, 1'b1);
    endtask

    initial begin
        RST_I = 1'b1; ENABLE_I = 1'b0; LOG_WRITE_I = 1'b0;
        LOG_WRITE_PTR_I = '0; LOG_DMEM_I = '0; LOG_READ_PTR_I = '0;
        HOST_REQ_I = 1'b1; HOST_WE_I = 1'b0; HOST_ADDR_I = '0; HOST_WDATA_I = '0;
        next(); next();
        #1;
        chk("rst_gnt", HOST_GNT_O, 1'b0);
        chk("rst_mem_en", MEM_EN_O, 1'b0);
        chk("rst_rw_turn", RW_TURN_O, 1'b0);
        chk("rst_err", ERR_O, 1'b0);
        chk("rst_rvalid", HOST_RVALID_O, 1'b0);
        HOST_REQ_I = 1'b0;
        RST_I = 1'b0; ph = 0;

        // Preload RAM in host-only mode.
        host_access(1'b1, 4'd0, 16'h0A0A);
        host_access(1'b1, 4'd1, 16'h0B0B);
        host_access(1'b1, 4'd2, 16'h0C0C);
        host_access(1'b1, 4'd3, 16'h0055);
        host_access(1'b1, 4'd7, 16'h1234);
        host_access(1'b1, 4'd9, 16'h0000);

        // Idle slot pattern.
        ENABLE_I = 1'b1;
        align(0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("idle_rw_turn", RW_TURN_O, (k % 4) == 0);
            chk("idle_write_allow", WRITE_ALLOW_O, (k % 4) == 0);
            chk("idle_mem_en", MEM_EN_O, (k % 4) == 1);
            next();
        end

        // Logger write in PH_W, then read back by host.
        LOG_WRITE_I = 1'b1; LOG_WRITE_PTR_I = 4'd5; LOG_DMEM_I = 16'h00AB;
        #1;
        chk("logw_en", MEM_EN_O, 1'b1);
        chk("logw_we", MEM_WE_O, 1'b1);
        chk("logw_addr", MEM_ADDR_O, 4'd5);
        chk("logw_data", MEM_WDATA_O, 16'h00AB);
        shadow[5] = 16'h00AB;
        next();
        LOG_WRITE_I = 1'b0;
        #1 chk("logw_no_err", ERR_O, 1'b0);
        host_access(1'b0, 4'd5, '0);

        // Host read raised in PH_W waits for PH_H.
        align(0);
        host_access(1'b0, 4'd3, '0);
        repeat (3) next();

        // Logger read prefetch, matching and moved pointer.
        align(1);
        LOG_READ_PTR_I = 4'd7;
        #1;
        chk("pf_addr", MEM_ADDR_O, 4'd7);
        chk("pf_we", MEM_WE_O, 1'b0);
        chk("pf_en", MEM_EN_O, 1'b1);
        chk("dmem_zero_ra", LOG_DMEM_O, 16'h0000);
        next();
        #1;
        chk("rd_allow", READ_ALLOW_O, 1'b1);
        chk("rd_data", LOG_DMEM_O, 16'h1234);
        align(1);
        LOG_READ_PTR_I = 4'd7;
        next();
        LOG_READ_PTR_I = 4'd8;
        #1 chk("rd_ptr_moved", READ_ALLOW_O, 1'b0);

        // Enable rising in PH_RD finds no prefetch.
        align(1);
        ENABLE_I = 1'b0; LOG_READ_PTR_I = 4'd7;
        next();
        ENABLE_I = 1'b1;
        #1 chk("rd_enable_rise", READ_ALLOW_O, 1'b0);
        next();

        // Host-only back-to-back reads.
        ENABLE_I = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            HOST_REQ_I = 1'b1; HOST_WE_I = 1'b0; HOST_ADDR_I = AW'(i);
            #1;
            chk("b2b_gnt", HOST_GNT_O, 1'b1);
            chk("b2b_rw_turn", RW_TURN_O, 1'b0);
            e.data = shadow[i]; e.cyc = cyc;
            sb.push_back(e);
            next();
        end
        HOST_REQ_I = 1'b0;
        repeat (4) next();
        chk("b2b_drained", sb.size(), 0);

        // Logger write outside its slot.
        ENABLE_I = 1'b1;
        align(1);
        LOG_WRITE_I = 1'b1; LOG_WRITE_PTR_I = 4'd9; LOG_DMEM_I = 16'hDEAD;
        #1;
        chk("err_we_blocked", MEM_WE_O, 1'b0);
        chk("err_not_yet", ERR_O, 1'b0);
        next();
        LOG_WRITE_I = 1'b0;
        #1 chk("err_set", ERR_O, 1'b1);
        host_access(1'b0, 4'd9, '0);
        repeat (3) next();

        // Reset during a pending host read.
        align(0);
        host_access(1'b0, 4'd2, '0);
        RST_I = 1'b1; ph = 0;
        #1;
        chk("rst2_rvalid", HOST_RVALID_O, 1'b0);
        chk("rst2_err", ERR_O, 1'b0);
        chk("rst2_mem_en", MEM_EN_O, 1'b0);
        chk("rst2_rw_turn", RW_TURN_O, 1'b0);
        sb.delete();
        next(); next();
        RST_I = 1'b0; ph = 0;
        #1;
        chk("rst2_phase_w", RW_TURN_O, 1'b1);
        chk("rst2_write_allow", WRITE_ALLOW_O, 1'b1);
        next(); next(); next();
        chk("rst2_err_clear", ERR_O, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trb_mem_scheduler.md
Name: trb_mem_scheduler

Overview:
- Time-division scheduler and arbiter for the trace-buffer single-port synchronous RAM.
- Sequences the logger's write and read turns by generating the logger's turn strobe and its write-allow/read-allow qualifiers.
- Prefetches the logger's read word so it is valid in the logger's read cycle.
- Gives a host/debug access port a fixed slot, or every cycle when tracing is disabled.
- Sits between the trace logger, the debug interface and the RAM macro.

Parameters:
ADDR_WIDTH, TRB_ADDR_WIDTH, RAM address width
DATA_WIDTH, TRB_WIDTH, RAM word width

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset, asynchronous, active-high
ENABLE_I  in  1  logger owns its slots when 1; host-only mode when 0
RW_TURN_O  out  1  logger turn strobe: 1 = write turn, 0 = read/other
WRITE_ALLOW_O  out  1  logger write permitted this cycle
READ_ALLOW_O  out  1  logger read data valid this cycle
LOG_WRITE_I  in  1  logger write strobe
LOG_WRITE_PTR_I  in  ADDR_WIDTH  logger write address
LOG_DMEM_I  in  DATA_WIDTH  logger write data
LOG_READ_PTR_I  in  ADDR_WIDTH  logger read address
LOG_DMEM_O  out  DATA_WIDTH  read data to logger
HOST_REQ_I  in  1  host access request, held until granted
HOST_WE_I  in  1  host write (1) / read (0)
HOST_ADDR_I  in  ADDR_WIDTH  host address
HOST_WDATA_I  in  DATA_WIDTH  host write data
HOST_GNT_O  out  1  host access accepted this cycle
HOST_RVALID_O  out  1  host read data valid, 1-cycle pulse
HOST_RDATA_O  out  DATA_WIDTH  host read data, held until next RVALID
MEM_EN_O  out  1  RAM enable
MEM_WE_O  out  1  RAM write enable
MEM_ADDR_O  out  ADDR_WIDTH  RAM address
MEM_WDATA_O  out  DATA_WIDTH  RAM write data
MEM_RDATA_I  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read issue
ERR_O  out  1  sticky protocol error

Behaviour:
Phase state:
- 2-bit phase register cycles PH_W, PH_RA, PH_RD, PH_H, PH_W, ... every cycle, independent of ENABLE_I.
- Async reset sets phase=PH_W and clears all registers.
- While RST_I is high, all outputs are 0.

Outputs are combinational from the phase register, ENABLE_I and the request inputs. No RAM control output is registered, so RAM access happens in the same cycle as the logger's strobe.

ENABLE_I=1:
- PH_W:
  - RW_TURN_O=1, WRITE_ALLOW_O=1.
  - MEM_EN_O=MEM_WE_O=LOG_WRITE_I; MEM_ADDR_O=LOG_WRITE_PTR_I; MEM_WDATA_O=LOG_DMEM_I.
- PH_RA:
  - RW_TURN_O=0. Issue RAM read: MEM_EN_O=1, MEM_WE_O=0, MEM_ADDR_O=LOG_READ_PTR_I.
  - Register pf_addr<=LOG_READ_PTR_I and pf_valid<=1.
- PH_RD:
  - RW_TURN_O=0. LOG_DMEM_O=MEM_RDATA_I.
  - READ_ALLOW_O=pf_valid && (pf_addr==LOG_READ_PTR_I); a pointer change since PH_RA suppresses the read.
  - pf_valid<=0 at end of PH_RD.
- PH_H:
  - RW_TURN_O=0, both allows 0.
  - HOST_GNT_O=HOST_REQ_I. On grant: MEM_EN_O=1, MEM_WE_O=HOST_WE_I, MEM_ADDR_O=HOST_ADDR_I, MEM_WDATA_O=HOST_WDATA_I.
- Host is never granted in PH_W/PH_RA/PH_RD. Worst-case grant wait is 3 cycles.

ENABLE_I=0:
- RW_TURN_O, WRITE_ALLOW_O and READ_ALLOW_O are 0.
- pf_valid is cleared.
- HOST_GNT_O=HOST_REQ_I in every phase.

Enable changes:
- Take effect in the same cycle; no drain.
- Enable rising in PH_RD gives READ_ALLOW_O=0 because pf_valid=0.

Host read return:
- A read granted in cycle t puts data on MEM_RDATA_I at t+1.
- rd_pend_q<=1 at end of t; at end of t+1, HOST_RDATA_O<=MEM_RDATA_I and HOST_RVALID_O<=1.
- HOST_RVALID_O is high during t+2 only. Fixed 2-cycle latency, fully pipelined; back-to-back reads are allowed in host-only mode.
- Host writes produce no response beyond HOST_GNT_O.

Error flag:
- ERR_O is set when LOG_WRITE_I=1 while WRITE_ALLOW_O=0, and remains set until reset.
- That write is not forwarded to the RAM.

Other rules:
- LOG_DMEM_O is 0 outside PH_RD.
- Reset mid-operation aborts any pending host read: no RVALID is issued and phase restarts at PH_W.

Test Plan:
- Release reset, ENABLE_I=1, no requests -> RW_TURN_O sequence 1,0,0,0 repeating; WRITE_ALLOW_O high only in PH_W; MEM_EN_O low except in PH_RA.
- PH_W with LOG_WRITE_I=1, ptr=5, data=0xAB -> MEM_EN_O=MEM_WE_O=1, MEM_ADDR_O=5, MEM_WDATA_O=0xAB in that cycle; a read back via host returns 0xAB.
- RAM[7]=0x1234, LOG_READ_PTR_I=7 -> PH_RA MEM_ADDR_O=7 and MEM_WE_O=0; PH_RD READ_ALLOW_O=1 and LOG_DMEM_O=0x1234. Repeat with ptr changed 7->8 between PH_RA and PH_RD -> READ_ALLOW_O=0.
- Host read of addr 3 (RAM[3]=0x55) raised in PH_W and held -> HOST_GNT_O only in PH_H; HOST_RVALID_O 2 cycles later with HOST_RDATA_O=0x55.
- ENABLE_I=0, four back-to-back host reads of addrs 0..3 -> grant every cycle; RVALID on 4 consecutive cycles starting 2 cycles after the first grant; data in order; RW_TURN_O=0 throughout.
- LOG_WRITE_I=1 in PH_RA -> ERR_O=1 from the next cycle with no RAM write. Assert RST_I mid host read -> all outputs 0 immediately, no RVALID, phase restarts at PH_W, ERR_O cleared.
